lsu_controller: RTL and testbench

Load/store sequencer between the core datapath and the data-memory port. It takes the decoder's memory controls (request, write enable, access size), the ALU-computed address and the rs2 store data. It then runs a single memory transaction through a ready handshake, stalling the core until the transaction completes. It also generates byte enables, replicates store data, extracts and extends load data, and flags misaligned or illegal-size accesses without issuing them to memory.

---
 rtl/lsu_controller.sv | 180 ++++++++++++++++++
 tb/tb_lsu_controller.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : lsu_controller                                              |
// | Purpose  : Load/store sequencer for a single data-memory port; stalls  |
// |            the core and shapes byte enables, store and load data.      |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module lsu_controller (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic [2:0]  core_size_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wd_i,
   output logic [31:0] core_rd_o,
   output logic        core_stall_o,
   output logic        fault_o,
   output logic [31:0] fault_addr_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wd_o,
   input  logic [31:0] mem_rd_i,
   input  logic        mem_ready_i
);

   localparam logic [2:0] c_ldst_b  = 3'd0;
   localparam logic [2:0] c_ldst_h  = 3'd1;
   localparam logic [2:0] c_ldst_w  = 3'd2;
   localparam logic [2:0] c_ldst_bu = 3'd4;
   localparam logic [2:0] c_ldst_hu = 3'd5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DONE  = 2'd2,
      FAULT = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next_state;

   logic        r_we;
   logic [2:0]  r_size;
   logic [31:0] r_addr;
   logic [31:0] r_wd;
   logic [31:0] r_rdata;

   logic        w_legal_size;
   logic        w_misaligned;
   logic        w_fault;
   logic        w_accept;
   logic        w_reject;
   logic        w_stall;
   logic        w_busy;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_ext;
   logic [3:0]  w_be;
   logic [31:0] w_wd_rep;

   // Size bits [1:0] give the width (00 byte, 01 half, 10 word); bit 2 marks unsigned loads.
   always_comb begin
      w_legal_size = (core_size_i == c_ldst_b)  || (core_size_i == c_ldst_h)  ||
                     (core_size_i == c_ldst_w)  || (core_size_i == c_ldst_bu) ||
                     (core_size_i == c_ldst_hu);
      w_misaligned = ((core_size_i[1:0] == 2'b01) && core_addr_i[0]) ||
                     ((core_size_i == c_ldst_w) && (core_addr_i[1:0] != 2'b00));
      w_fault      = !w_legal_size || w_misaligned;
   end

   always_comb begin
      w_next_state = r_state;
      w_stall      = 1'b0;
      w_accept     = 1'b0;
      w_reject     = 1'b0;
      case (r_state)
         IDLE: begin
            if (core_req_i) begin
               w_stall = 1'b1;
               if (w_fault) begin
                  w_reject     = 1'b1;
                  w_next_state = FAULT;
               end else begin
                  w_accept     = 1'b1;
                  w_next_state = BUSY;
               end
            end
         end
         BUSY: begin
            w_stall = 1'b1;
            if (mem_ready_i) begin
               w_next_state = DONE;
            end
         end
         DONE:    w_next_state = IDLE;
         FAULT:   w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      case (r_addr[1:0])
         2'd0:    w_byte = mem_rd_i[7:0];
         2'd1:    w_byte = mem_rd_i[15:8];
         2'd2:    w_byte = mem_rd_i[23:16];
         default: w_byte = mem_rd_i[31:24];
      endcase
      w_half = r_addr[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
      case (r_size[1:0])
         2'b00:   w_load_ext = {{24{~r_size[2] & w_byte[7]}}, w_byte};
         2'b01:   w_load_ext = {{16{~r_size[2] & w_half[15]}}, w_half};
         default: w_load_ext = mem_rd_i;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_we    <= 1'b0;
         r_size  <= 3'd0;
         r_addr  <= 32'd0;
         r_wd    <= 32'd0;
         r_rdata <= 32'd0;
      end else begin
         if (w_accept) begin
            r_we   <= core_we_i;
            r_size <= core_size_i;
            r_addr <= core_addr_i;
            r_wd   <= core_wd_i;
         end else if (w_reject) begin
            r_addr <= core_addr_i;
         end
         if ((r_state == BUSY) && mem_ready_i) begin
            r_rdata <= r_we ? 32'd0 : w_load_ext;
         end
      end
   end

   always_comb begin
      case (r_size[1:0])
         2'b00: begin
            w_be     = 4'b0001 << r_addr[1:0];
            w_wd_rep = {4{r_wd[7:0]}};
         end
         2'b01: begin
            w_be     = r_addr[1] ? 4'b1100 : 4'b0011;
            w_wd_rep = {2{r_wd[15:0]}};
         end
         default: begin
            w_be     = 4'b1111;
            w_wd_rep = r_wd;
         end
      endcase
   end

   assign w_busy       = (r_state == BUSY);
   assign mem_req_o    = w_busy;
   assign mem_we_o     = w_busy & r_we;
   assign mem_be_o     = w_busy ? w_be : 4'b0000;
   assign mem_addr_o   = w_busy ? {r_addr[31:2], 2'b00} : 32'd0;
   assign mem_wd_o     = w_busy ? w_wd_rep : 32'd0;

   // Stall is combinational on core_req_i in IDLE, so it must be masked while reset is held.
   assign core_stall_o = w_stall & rst_ni;
   assign fault_o      = (r_state == FAULT);
   assign fault_addr_o = (r_state == FAULT) ? r_addr : 32'd0;
   assign core_rd_o    = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_lsu_controller                                           |
// | Purpose  : Table-driven and randomized self-checking bench for the     |
// |            load/store sequencer.                                       |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_lsu_controller;

   logic        clk_i;
   logic        rst_ni;
   logic        core_req_i;
   logic        core_we_i;
   logic [2:0]  core_size_i;
   logic [31:0] core_addr_i;
   logic [31:0] core_wd_i;
   logic [31:0] core_rd_o;
   logic        core_stall_o;
   logic        fault_o;
   logic [31:0] fault_addr_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wd_o;
   logic [31:0] mem_rd_i;
   logic        mem_ready_i;

   int n_pass;
   int n_total;

   typedef struct {
      logic        we;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      int          delay;
      logic        fault;
      logic [3:0]  be;
      logic [31:0] maddr;
      logic [31:0] mwd;
      logic [31:0] rdx;
   } rec_t;

   rec_t tbl[12];

   lsu_controller dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .core_req_i   (core_req_i),
      .core_we_i    (core_we_i),
      .core_size_i  (core_size_i),
      .core_addr_i  (core_addr_i),
      .core_wd_i    (core_wd_i),
      .core_rd_o    (core_rd_o),
      .core_stall_o (core_stall_o),
      .fault_o      (fault_o),
      .fault_addr_o (fault_addr_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_be_o     (mem_be_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wd_o     (mem_wd_o),
      .mem_rd_i     (mem_rd_i),
      .mem_ready_i  (mem_ready_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic rec_t mk(input logic we, input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [31:0] rd, input int delay,
                               input logic fault, input logic [3:0] be, input logic [31:0] maddr,
                               input logic [31:0] mwd, input logic [31:0] rdx);
      rec_t r;
      r.we = we; r.size = size; r.addr = addr; r.wd = wd; r.rd = rd; r.delay = delay;
      r.fault = fault; r.be = be; r.maddr = maddr; r.mwd = mwd; r.rdx = rdx;
      return r;
   endfunction

   // Reference: access width in bytes, lane offset, and arithmetic extraction/extension.
   function automatic rec_t model(input logic we, input logic [2:0] size, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [31:0] rd, input int delay);
      rec_t        r;
      int          n;
      int          lane;
      logic [63:0] mask;
      logic [31:0] v;
      r.we = we; r.size = size; r.addr = addr; r.wd = wd; r.rd = rd; r.delay = delay;
      n    = (size == 3'd2) ? 4 : ((size == 3'd1) || (size == 3'd5)) ? 2 : 1;
      lane = int'(addr % 4);
      r.fault = !((size == 3'd0) || (size == 3'd1) || (size == 3'd2) || (size == 3'd4) || (size == 3'd5))
                || ((lane % n) != 0);
      r.be    = 4'(((1 << n) - 1) << lane);
      r.maddr = addr - 32'(lane);
      for (int b = 0; b < 4; b++) begin
         r.mwd[8*b +: 8] = wd[8*(b % n) +: 8];
      end
      mask = (64'd1 << (8*n)) - 64'd1;
      v    = (rd >> (8*lane)) & mask[31:0];
      if ((size <= 3'd1) && (n < 4) && v[8*n-1]) begin
         v = v | ~mask[31:0];
      end
      r.rdx = we ? 32'd0 : v;
      return r;
   endfunction

   task automatic run_access(input rec_t r);
      int stalls;
      stalls      = 0;
      core_req_i  = 1'b1;
      core_we_i   = r.we;
      core_size_i = r.size;
      core_addr_i = r.addr;
      core_wd_i   = r.wd;
      mem_ready_i = 1'b0;
      mem_rd_i    = $urandom;
      @(negedge clk_i);
      if (core_stall_o) stalls++;
      check("accept_stall", {31'd0, core_stall_o}, 32'd1);
      check("accept_noreq", {31'd0, mem_req_o}, 32'd0);
      @(posedge clk_i); #1;
      if (r.fault) begin
         @(negedge clk_i);
         check("fault_pulse", {31'd0, fault_o}, 32'd1);
         check("fault_addr", fault_addr_o, r.addr);
         check("fault_stall", {31'd0, core_stall_o}, 32'd0);
         check("fault_noreq", {31'd0, mem_req_o}, 32'd0);
         @(posedge clk_i); #1;
         core_req_i = 1'b0;
         @(negedge clk_i);
         check("fault_once", {31'd0, fault_o}, 32'd0);
         check("fault_idle_noreq", {31'd0, mem_req_o}, 32'd0);
         @(posedge clk_i); #1;
      end else begin
         for (int k = 0; k <= r.delay; k++) begin
            mem_ready_i = (k == r.delay);
            mem_rd_i    = (k == r.delay) ? r.rd : $urandom;
            @(negedge clk_i);
            if (core_stall_o) stalls++;
            check("busy_req", {31'd0, mem_req_o}, 32'd1);
            check("busy_we", {31'd0, mem_we_o}, {31'd0, r.we});
            check("busy_be", {28'd0, mem_be_o}, {28'd0, r.be});
            check("busy_addr", mem_addr_o, r.maddr);
            if (r.we) check("busy_wd", mem_wd_o, r.mwd);
            check("busy_nofault", {31'd0, fault_o}, 32'd0);
            @(posedge clk_i); #1;
         end
         mem_ready_i = 1'b0;
         mem_rd_i    = $urandom;
         @(negedge clk_i);
         check("done_stall", {31'd0, core_stall_o}, 32'd0);
         check("done_rd", core_rd_o, r.rdx);
         check("done_noreq", {31'd0, mem_req_o}, 32'd0);
         check("stall_cycles", 32'(stalls), 32'(r.delay + 2));
         @(posedge clk_i); #1;
         core_req_i  = 1'b0;
         mem_ready_i = 1'b1;
         @(negedge clk_i);
         check("idle_stall", {31'd0, core_stall_o}, 32'd0);
         check("idle_noreq", {31'd0, mem_req_o}, 32'd0);
         @(posedge clk_i); #1;
         mem_ready_i = 1'b0;
         @(negedge clk_i);
         check("stray_ready_ignored", {31'd0, mem_req_o}, 32'd0);
         @(posedge clk_i); #1;
      end
   endtask

   initial begin
      rec_t r;
      logic [2:0] sz;
      logic       we;
      logic [31:0] a;
      n_pass      = 0;
      n_total     = 0;
      rst_ni      = 1'b0;
      core_req_i  = 1'b0;
      core_we_i   = 1'b0;
      core_size_i = 3'd0;
      core_addr_i = 32'd0;
      core_wd_i   = 32'd0;
      mem_rd_i    = 32'd0;
      mem_ready_i = 1'b0;

      //              we    size  addr          wd            rd            dly flt  be       maddr         mwd           rdx
      tbl[0]  = mk(1'b0, 3'd2, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 0, 1'b0, 4'b1111, 32'h0000_0100, 32'h0,        32'hDEADBEEF);
      tbl[1]  = mk(1'b0, 3'd0, 32'h0000_0103, 32'h0,        32'h80FF0000, 0, 1'b0, 4'b1000, 32'h0000_0100, 32'h0,        32'hFFFFFF80);
      tbl[2]  = mk(1'b0, 3'd4, 32'h0000_0103, 32'h0,        32'h80FF0000, 1, 1'b0, 4'b1000, 32'h0000_0100, 32'h0,        32'h00000080);
      tbl[3]  = mk(1'b1, 3'd1, 32'h0000_0206, 32'h1234ABCD, 32'h55555555, 0, 1'b0, 4'b1100, 32'h0000_0204, 32'hABCDABCD, 32'h0);
      tbl[4]  = mk(1'b0, 3'd2, 32'h0000_0102, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,         32'h0,        32'h0);
      tbl[5]  = mk(1'b0, 3'd3, 32'h0000_0100, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,         32'h0,        32'h0);
      tbl[6]  = mk(1'b0, 3'd5, 32'h0000_0010, 32'h0,        32'h12348765, 3, 1'b0, 4'b0011, 32'h0000_0010, 32'h0,        32'h00008765);
      tbl[7]  = mk(1'b0, 3'd1, 32'h0000_0012, 32'h0,        32'h87651234, 2, 1'b0, 4'b1100, 32'h0000_0010, 32'h0,        32'hFFFF8765);
      tbl[8]  = mk(1'b1, 3'd0, 32'h0000_0101, 32'h000000A5, 32'h0,        0, 1'b0, 4'b0010, 32'h0000_0100, 32'hA5A5A5A5, 32'h0);
      tbl[9]  = mk(1'b1, 3'd2, 32'h0000_0300, 32'hCAFEF00D, 32'h0,        1, 1'b0, 4'b1111, 32'h0000_0300, 32'hCAFEF00D, 32'h0);
      tbl[10] = mk(1'b0, 3'd5, 32'h0000_0111, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,         32'h0,        32'h0);
      tbl[11] = mk(1'b0, 3'd0, 32'h0000_0102, 32'h0,        32'h00560000, 0, 1'b0, 4'b0100, 32'h0000_0100, 32'h0,        32'h00000056);

      // Reset state, including stall masked while reset is held.
      repeat (2) @(posedge clk_i);
      #1;
      core_req_i  = 1'b1;
      core_size_i = 3'd2;
      @(negedge clk_i);
      check("rst_stall", {31'd0, core_stall_o}, 32'd0);
      check("rst_req", {31'd0, mem_req_o}, 32'd0);
      check("rst_be", {28'd0, mem_be_o}, 32'd0);
      check("rst_addr", mem_addr_o, 32'd0);
      check("rst_wd", mem_wd_o, 32'd0);
      check("rst_fault", {31'd0, fault_o}, 32'd0);
      check("rst_fault_addr", fault_addr_o, 32'd0);
      check("rst_rd", core_rd_o, 32'd0);
      rst_ni = 1'b1;
      #1;
      check("idle_comb_stall", {31'd0, core_stall_o}, 32'd1);
      core_req_i = 1'b0;
      #1;
      check("idle_comb_nostall", {31'd0, core_stall_o}, 32'd0);
      @(posedge clk_i); #1;

      for (int i = 0; i < 12; i++) begin
         run_access(tbl[i]);
      end

      // Reset asserted in the middle of BUSY abandons the access.
      core_req_i  = 1'b1;
      core_we_i   = 1'b0;
      core_size_i = 3'd2;
      core_addr_i = 32'h0000_0040;
      @(posedge clk_i); #1;
      @(negedge clk_i);
      check("midrst_busy_req", {31'd0, mem_req_o}, 32'd1);
      #1;
      rst_ni = 1'b0;
      #1;
      check("midrst_req_drop", {31'd0, mem_req_o}, 32'd0);
      check("midrst_stall_drop", {31'd0, core_stall_o}, 32'd0);
      check("midrst_be_drop", {28'd0, mem_be_o}, 32'd0);
      mem_ready_i = 1'b1;
      mem_rd_i    = 32'h1111_2222;
      @(posedge clk_i); #1;
      core_req_i  = 1'b0;
      mem_ready_i = 1'b0;
      rst_ni      = 1'b1;
      @(negedge clk_i);
      check("postrst_rd", core_rd_o, 32'd0);
      check("postrst_idle", {31'd0, mem_req_o}, 32'd0);
      @(posedge clk_i); #1;
      run_access(mk(1'b0, 3'd2, 32'h0000_0040, 32'h0, 32'h0BAD_F00D, 1, 1'b0, 4'b1111,
                    32'h0000_0040, 32'h0, 32'h0BAD_F00D));

      // Randomized accesses against the reference model.
      for (int i = 0; i < 150; i++) begin
         sz = 3'($urandom_range(0, 7));
         we = 1'($urandom);
         if (we && sz[2] && (sz[1:0] != 2'b11) && (sz[1:0] != 2'b10)) sz[2] = 1'b0;
         a = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         r = model(we, sz, a, $urandom, $urandom, int'($urandom_range(0, 3)));
         run_access(r);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
